if_prefetch_stage: RTL



---
 rtl/if_prefetch_stage_pkg.sv | 27 ++
 rtl/if_prefetch_stage_if.sv | 32 +++
 rtl/if_prefetch_stage_chk.sv | 26 ++
 rtl/if_prefetch_stage_fifo.sv | 71 +++++++
 rtl/if_prefetch_stage.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/if_prefetch_stage_pkg.sv
// Shared definitions for the instruction-fetch prefetch stage: default
// widths, the queue entry layout and helpers that size counters/pointers.
package if_prefetch_stage_pkg;

    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_INST_W   = 32;
    localparam int DEF_DEPTH    = 4;
    localparam int DEF_RESET_PC = 0;
    localparam int DEF_PC_STEP  = 4;

    // One prefetched instruction together with the PC that ID expects to see.
    typedef struct packed {
        logic [DEF_INST_W-1:0] inst;
        logic [DEF_ADDR_W-1:0] pc_next;
    } fetch_entry_t;

    // Width able to hold 0..depth inclusive.
    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Width of a pointer into a depth-entry array (at least one bit).
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/if_prefetch_stage_if.sv
// Bus bundle of the fetch stage: hazard/redirect inputs, instruction-memory
// request/response channel and the head-of-queue view presented to ID.
// "master" is the fetch stage side, "slave" is the surrounding pipeline/memory.
interface if_prefetch_stage_if
    import if_prefetch_stage_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int INST_W = DEF_INST_W
);
    logic              freeze;
    logic              Branch_taken;
    logic [ADDR_W-1:0] BranchAddr;
    logic              mem_req_valid;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_rsp_valid;
    logic [INST_W-1:0] mem_rsp_data;
    logic              inst_valid;
    logic [INST_W-1:0] Instruction;
    logic [ADDR_W-1:0] PC;
    logic              rsp_err;

    modport master (
        input  freeze, Branch_taken, BranchAddr, mem_rsp_valid, mem_rsp_data,
        output mem_req_valid, mem_req_addr, inst_valid, Instruction, PC, rsp_err
    );

    modport slave (
        output freeze, Branch_taken, BranchAddr, mem_rsp_valid, mem_rsp_data,
        input  mem_req_valid, mem_req_addr, inst_valid, Instruction, PC, rsp_err
    );

endinterface

// File: rtl/if_prefetch_stage_chk.sv
// Invariant checker for the fetch stage credit/discard bookkeeping.
module if_prefetch_stage_chk #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input logic             clk,
    input logic             rst,
    input logic             push,
    input logic             pop,
    input logic [CNT_W-1:0] occ,
    input logic [CNT_W-1:0] outstanding,
    input logic [CNT_W-1:0] discard
);
    // Queued plus in-flight requests never exceed the queue capacity.
    a_credit: assert property (@(posedge clk) disable iff (rst)
        (int'(occ) + int'(outstanding)) <= DEPTH);

    // The credit rule makes a push into a full, non-popping queue impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (int'(occ) == DEPTH)));

    // Only requests still in flight can be pending discard.
    a_discard_bound: assert property (@(posedge clk) disable iff (rst)
        discard <= outstanding);

endmodule

// File: rtl/if_prefetch_stage_fifo.sv
// Synchronous first-word-fall-through queue holding prefetched instructions.
// A flush empties it in one cycle; occupancy is exported for credit accounting.
module if_prefetch_stage_fifo
    import if_prefetch_stage_pkg::*;
#(
    parameter int  DEPTH   = DEF_DEPTH,
    parameter int  CNT_W   = count_w(DEF_DEPTH),
    parameter type entry_t = fetch_entry_t
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  entry_t           wdata,
    output entry_t           head,
    output logic             head_valid,
    output logic [CNT_W-1:0] occ
);
    localparam int PTR_W = ptr_w(DEPTH);

    entry_t           mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Never pop an empty queue; never write a full one unless a pop frees a slot.
    always_comb begin
        do_pop_s  = pop & (count_r != {CNT_W{1'b0}});
        do_push_s = push & ((count_r != CNT_W'(DEPTH)) | do_pop_s);
    end

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are only observed while counted as valid, so no reset.
    always_ff @(posedge clk) begin
        if (!rst && !flush && do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    assign head       = mem_r[rd_ptr_r];
    assign head_valid = (count_r != {CNT_W{1'b0}});
    assign occ        = count_r;

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: issues in-order fetches under a credit limit,
// buffers responses in a prefetch queue and presents {instruction, PC+step}
// to ID. A taken branch flushes the queue, marks in-flight fetches for
// discard and redirects the fetch PC.
module if_prefetch_stage
    import if_prefetch_stage_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                INST_W   = DEF_INST_W,
    parameter int                DEPTH    = DEF_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
    parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(DEF_PC_STEP)
) (
    input logic                 clk,
    input logic                 rst,
    if_prefetch_stage_if.master bus
);
    localparam int CNT_W = count_w(DEPTH);
    localparam logic [CNT_W:0] CREDIT_LIMIT = (CNT_W + 1)'(DEPTH);

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc_next;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc_r;
    logic [ADDR_W-1:0] rsp_pc_r;      // fetch address of the next response that will be kept
    logic [CNT_W-1:0]  outstanding_r;
    logic [CNT_W-1:0]  discard_r;
    logic              rsp_err_r;

    logic [CNT_W-1:0]  occ_s;
    logic              head_valid_s;
    entry_t            head_s;
    entry_t            push_entry_s;
    logic [CNT_W:0]    credit_sum_s;
    logic              issue_s;
    logic              pop_s;
    logic              push_s;
    logic              rsp_drop_s;
    logic              rsp_keep_s;
    logic              rsp_stray_s;
    logic [CNT_W-1:0]  redirect_cnt_s;

    // Issue/pop decisions; a redirect or reset suppresses both.
    always_comb begin
        credit_sum_s = {1'b0, occ_s} + {1'b0, outstanding_r};
        issue_s      = !rst && !bus.Branch_taken && (credit_sum_s < CREDIT_LIMIT);
        pop_s        = head_valid_s && !bus.freeze && !bus.Branch_taken;
    end

    // Classify an arriving response: stale (discard), kept, or unexpected.
    always_comb begin
        rsp_drop_s  = 1'b0;
        rsp_keep_s  = 1'b0;
        rsp_stray_s = 1'b0;
        if (!bus.mem_rsp_valid) begin
            rsp_drop_s = 1'b0;
        end else if (discard_r != {CNT_W{1'b0}}) begin
            rsp_drop_s = 1'b1;
        end else if (outstanding_r != {CNT_W{1'b0}}) begin
            rsp_keep_s = 1'b1;
        end else begin
            rsp_stray_s = 1'b1;
        end
        push_s = rsp_keep_s && !bus.Branch_taken;
    end

    // Requests left in flight after a redirect; a response in the redirect cycle is consumed.
    always_comb begin
        if (bus.mem_rsp_valid && (outstanding_r != {CNT_W{1'b0}})) begin
            redirect_cnt_s = outstanding_r - CNT_W'(1);
        end else begin
            redirect_cnt_s = outstanding_r;
        end
    end

    // Fetch PC, response tracking and error flag; redirect overrides normal flow.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r    <= RESET_PC;
            rsp_pc_r      <= RESET_PC;
            outstanding_r <= {CNT_W{1'b0}};
            discard_r     <= {CNT_W{1'b0}};
            rsp_err_r     <= 1'b0;
        end else if (bus.Branch_taken) begin
            fetch_pc_r    <= bus.BranchAddr;
            rsp_pc_r      <= bus.BranchAddr;
            outstanding_r <= redirect_cnt_s;
            discard_r     <= redirect_cnt_s;
            if (bus.mem_rsp_valid && (outstanding_r == {CNT_W{1'b0}})) begin
                rsp_err_r <= 1'b1;
            end
        end else begin
            if (issue_s) begin
                fetch_pc_r <= fetch_pc_r + PC_STEP;
            end
            if (push_s) begin
                rsp_pc_r <= rsp_pc_r + PC_STEP;
            end
            outstanding_r <= outstanding_r + CNT_W'(issue_s) - CNT_W'(rsp_drop_s | rsp_keep_s);
            discard_r     <= discard_r - CNT_W'(rsp_drop_s);
            if (rsp_stray_s) begin
                rsp_err_r <= 1'b1;
            end
        end
    end

    assign push_entry_s.inst    = bus.mem_rsp_data;
    assign push_entry_s.pc_next = rsp_pc_r + PC_STEP;

    if_prefetch_stage_fifo #(
        .DEPTH   (DEPTH),
        .CNT_W   (CNT_W),
        .entry_t (entry_t)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (bus.Branch_taken),
        .push       (push_s),
        .pop        (pop_s),
        .wdata      (push_entry_s),
        .head       (head_s),
        .head_valid (head_valid_s),
        .occ        (occ_s)
    );

    if_prefetch_stage_chk #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_chk (
        .clk         (clk),
        .rst         (rst),
        .push        (push_s),
        .pop         (pop_s),
        .occ         (occ_s),
        .outstanding (outstanding_r),
        .discard     (discard_r)
    );

    assign bus.mem_req_valid = issue_s;
    assign bus.mem_req_addr  = fetch_pc_r;
    assign bus.inst_valid    = head_valid_s;
    assign bus.Instruction   = head_valid_s ? head_s.inst : {INST_W{1'b0}};
    assign bus.PC            = head_valid_s ? head_s.pc_next : {ADDR_W{1'b0}};
    assign bus.rsp_err       = rsp_err_r;

endmodule
